// File: rtl/idct_x0_if.sv
// Handshake and data bundle between the coefficient source and the x0
// reconstruction engine. The source side drives en/start/coefficients;
// the engine side returns busy, the result strobe and the sample.
interface idct_x0_if #(
  parameter int COEF_W = 19,
  parameter int OUT_W  = 8
);
  logic                     en;
  logic                     start;
  logic signed [COEF_W-1:0] coef0;
  logic signed [COEF_W-1:0] coef1;
  logic signed [COEF_W-1:0] coef2;
  logic signed [COEF_W-1:0] coef3;
  logic signed [COEF_W-1:0] coef4;
  logic signed [COEF_W-1:0] coef5;
  logic signed [COEF_W-1:0] coef6;
  logic signed [COEF_W-1:0] coef7;
  logic                     busy;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  sample_out;

  modport master (
    output en, start, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
    input  busy, out_valid, sample_out
  );

  modport slave (
    input  en, start, coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
    output busy, out_valid, sample_out
  );
endinterface

// File: rtl/idct_x0.sv
// Bit-serial distributed-arithmetic reconstruction of sample x0 from the
// eight DCT coefficients of one block. Coefficient bit-planes are consumed
// MSB-first; each plane addresses a sum-of-basis-constants table and the
// accumulator is doubled and added (sign plane subtracted) every cycle.
module idct_x0 #(
  parameter int COEF_W  = 19,
  parameter int CONST_W = 14,
  parameter int FRAC    = 12,
  parameter int OUT_W   = 8,
  parameter int C0      = 1448,
  parameter int C1      = 2009,
  parameter int C2      = 1892,
  parameter int C3      = 1703,
  parameter int C4      = 1448,
  parameter int C5      = 1138,
  parameter int C6      = 784,
  parameter int C7      = 400
) (
  input  logic      clk,
  input  logic      rst,
  idct_x0_if.slave  bus
);

  localparam int ROM_W = CONST_W + 3;
  localparam int ACC_W = COEF_W + CONST_W + 3;
  localparam int BW    = $clog2(COEF_W);
  localparam logic [BW-1:0] B_TOP = BW'(COEF_W - 1);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = -(ACC_W'(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Sum of the basis constants selected by one coefficient bit-plane.
  function automatic logic signed [ROM_W-1:0] rom_sum(input logic [7:0] a);
    logic signed [ROM_W-1:0] s;
    s = '0;
    if (a[0]) s = s + ROM_W'(C0);
    if (a[1]) s = s + ROM_W'(C1);
    if (a[2]) s = s + ROM_W'(C2);
    if (a[3]) s = s + ROM_W'(C3);
    if (a[4]) s = s + ROM_W'(C4);
    if (a[5]) s = s + ROM_W'(C5);
    if (a[6]) s = s + ROM_W'(C6);
    if (a[7]) s = s + ROM_W'(C7);
    return s;
  endfunction

  // Round half toward +inf, drop the fraction, clamp to the output range.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + HALF) >>> FRAC;
    if (r > YMAX)      r = YMAX;
    else if (r < YMIN) r = YMIN;
    return OUT_W'(r);
  endfunction

  state_t                   state_q, state_d;
  logic signed [COEF_W-1:0] coef_q [8];
  logic signed [COEF_W-1:0] coef_d [8];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [BW-1:0]            b_q, b_d;
  logic signed [OUT_W-1:0]  samp_q, samp_d;
  logic [7:0]               addr;
  logic signed [ROM_W-1:0]  rom;
  logic signed [ACC_W-1:0]  rom_ext;
  logic                     take;

  // Current bit-plane address and its partial sum, sign-extended to the accumulator.
  always_comb begin
    addr = '0;
    for (int k = 0; k < 8; k++) addr[k] = coef_q[k][b_q];
    rom     = rom_sum(addr);
    rom_ext = ACC_W'(rom);
  end

  // Next-state and datapath update; everything holds while en is low.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    coef_d  = coef_q;
    samp_d  = samp_q;
    take    = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            take    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          // The MSB plane carries negative weight in two's complement.
          if (b_q == B_TOP) acc_d = -rom_ext;
          else              acc_d = (acc_q <<< 1) + rom_ext;
          if (b_q == '0) begin
            state_d = DONE;
            samp_d  = round_sat(acc_d);
          end else begin
            b_d = b_q - BW'(1);
          end
        end
        DONE: begin
          if (bus.start) begin
            take    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (take) begin
      coef_d[0] = bus.coef0;
      coef_d[1] = bus.coef1;
      coef_d[2] = bus.coef2;
      coef_d[3] = bus.coef3;
      coef_d[4] = bus.coef4;
      coef_d[5] = bus.coef5;
      coef_d[6] = bus.coef6;
      coef_d[7] = bus.coef7;
      b_d       = B_TOP;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Coefficient, accumulator, bit index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q <= '{default: '0};
      acc_q  <= '0;
      b_q    <= '0;
      samp_q <= '0;
    end else begin
      coef_q <= coef_d;
      acc_q  <= acc_d;
      b_q    <= b_d;
      samp_q <= samp_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.out_valid  = (state_q == DONE) && bus.en;
  assign bus.sample_out = samp_q;

endmodule
